// File: rtl/basic_hashfunc.sv
// Fold-XOR hash: maps a wide key onto a table index in 0..TABLE_SZ-1.
// The combinational result is in hf_out; hf_out_q/hf_vld is a one-cycle registered copy.
module basic_hashfunc #(
   parameter int INPUT_SZ = 48,
   parameter int TABLE_SZ = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [INPUT_SZ-1:0]           hf_in,
   input  logic                          hf_en,
   output logic [$clog2(TABLE_SZ)-1:0]   hf_out,
   output logic [$clog2(TABLE_SZ)-1:0]   hf_out_q,
   output logic                          hf_vld
);

   localparam int FSZ   = $clog2(TABLE_SZ);
   localparam int FOLDS = (INPUT_SZ + FSZ - 1) / FSZ;
   localparam int PSZ   = FOLDS * FSZ;

   logic [PSZ-1:0] padded;
   logic [FSZ-1:0] fold;

   // Pad bits above INPUT_SZ stay zero, so a short key passes through unchanged.
   always_comb begin
      padded                 = '0;
      padded[INPUT_SZ-1:0]   = hf_in;
   end

   always_comb begin
      fold = '0;
      for (int k = 0; k < FOLDS; k++) begin
         fold = fold ^ padded[k*FSZ +: FSZ];
      end
   end

   // fold < 2^FSZ < 2*TABLE_SZ, so one conditional subtract brings it into range.
   generate
      if (TABLE_SZ == (1 << FSZ)) begin : g_pow2
         assign hf_out = fold;
      end else begin : g_reduce
         localparam logic [FSZ-1:0] TBL = TABLE_SZ[FSZ-1:0];
         assign hf_out = (fold >= TBL) ? (fold - TBL) : fold;
      end
   endgenerate

   // hf_en is a single-cycle capture strobe; hf_vld is that strobe delayed one
   // cycle and qualifies hf_out_q. There is no back-pressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hf_out_q <= '0;
         hf_vld   <= 1'b0;
      end else begin
         hf_vld <= hf_en;
         if (hf_en) begin
            hf_out_q <= hf_out;
         end
      end
   end

endmodule

// File: tb/tb_basic_hashfunc.sv
// Directed and random checks of basic_hashfunc in three parameterisations,
// with a queue of expected registered results.
module tb_basic_hashfunc;

   logic        clk;
   logic        reset;
   logic [47:0] hf_in;
   logic        hf_en;
   logic [9:0]  hf_out;
   logic [9:0]  hf_out_q;
   logic        hf_vld;

   logic [47:0] k1000;
   logic [9:0]  o1000;
   logic [9:0]  o1000_q;
   logic        v1000;

   logic [7:0]  k8;
   logic [9:0]  o8;
   logic [9:0]  o8_q;
   logic        v8;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];
   logic [9:0] held;

   basic_hashfunc dut (
      .clk(clk), .reset(reset), .hf_in(hf_in), .hf_en(hf_en),
      .hf_out(hf_out), .hf_out_q(hf_out_q), .hf_vld(hf_vld)
   );

   basic_hashfunc #(.INPUT_SZ(48), .TABLE_SZ(1000)) dut1000 (
      .clk(clk), .reset(reset), .hf_in(k1000), .hf_en(1'b0),
      .hf_out(o1000), .hf_out_q(o1000_q), .hf_vld(v1000)
   );

   basic_hashfunc #(.INPUT_SZ(8), .TABLE_SZ(1024)) dut8 (
      .clk(clk), .reset(reset), .hf_in(k8), .hf_en(1'b0),
      .hf_out(o8), .hf_out_q(o8_q), .hf_vld(v8)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: key bit i lands on fold bit (i mod FSZ), then reduce by TABLE_SZ.
   function automatic int ref_hash(input logic [47:0] key, input int isz, input int tsz);
      int fsz;
      int f;
      fsz = $clog2(tsz);
      f   = 0;
      for (int i = 0; i < isz; i++) begin
         if (key[i]) f = f ^ (1 << (i % fsz));
      end
      if (f >= tsz) f = f - tsz;
      return f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus on the default instance, scored on the following edge.
   task automatic step(input logic [47:0] key, input logic en);
      logic [9:0] e;
      int r;
      @(negedge clk);
      hf_in = key;
      hf_en = en;
      if (en) begin
         r = ref_hash(key, 48, 1024);
         e = r[9:0];
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("vld", {31'd0, hf_vld}, {31'd0, en});
      if (en) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
         end else begin
            held = exp_q.pop_front();
            chk("out_q", {22'd0, hf_out_q}, {22'd0, held});
         end
      end else begin
         chk("hold", {22'd0, hf_out_q}, {22'd0, held});
      end
   endtask

   initial begin
      logic [47:0] rk;
      int r;
      reset = 1'b1;
      hf_en = 1'b0;
      hf_in = 48'h1;
      k1000 = 48'h0;
      k8    = 8'h0;
      held  = 10'h0;
      #2;
      chk("rst_out_q", {22'd0, hf_out_q}, 32'd0);
      chk("rst_vld", {31'd0, hf_vld}, 32'd0);
      chk("rst_comb", {22'd0, hf_out}, 32'd1);

      @(negedge clk);
      reset = 1'b0;

      // Default combinational vectors
      hf_in = 48'h0;              #1; chk("zero", {22'd0, hf_out}, 32'h000);
      hf_in = 48'h000000000001;   #1; chk("one", {22'd0, hf_out}, 32'h001);
      hf_in = 48'h000000000401;   #1; chk("cancel", {22'd0, hf_out}, 32'h000);
      hf_in = 48'hFFFFFFFFFFFF;   #1; chk("ones", {22'd0, hf_out}, 32'h0FF);
      hf_in = 48'h000000000C00;   #1; chk("chunk1", {22'd0, hf_out}, 32'h003);
      hf_in = 48'hFF0000000000;   #1; chk("top_chunk", {22'd0, hf_out}, 32'h0FF);

      // TABLE_SZ=1000 boundaries
      k1000 = 48'h3FF; #1; chk("t1000_3ff", {22'd0, o1000}, 32'd23);
      k1000 = 48'h3E7; #1; chk("t1000_999", {22'd0, o1000}, 32'd999);
      k1000 = 48'h3E8; #1; chk("t1000_1000", {22'd0, o1000}, 32'd0);

      // INPUT_SZ=8 single fold
      k8 = 8'hA5; #1; chk("narrow", {22'd0, o8}, 32'h0A5);

      for (int i = 0; i < 40; i++) begin
         rk = {$urandom(), $urandom_range(0, 65535)};
         k1000 = rk;
         hf_in = rk;
         k8    = rk[7:0];
         #1;
         r = ref_hash(rk, 48, 1000);
         chk("t1000_rand", {22'd0, o1000}, r);
         chk("t1000_range", {31'd0, (o1000 < 10'd1000)}, 32'd1);
         r = ref_hash(rk, 48, 1024);
         chk("dflt_rand", {22'd0, hf_out}, r);
         r = ref_hash({40'd0, rk[7:0]}, 8, 1024);
         chk("narrow_rand", {22'd0, o8}, r);
      end

      // Registered path
      step(48'h1, 1'b1);
      step(48'h123456789ABC, 1'b0);
      for (int i = 0; i < 12; i++) begin
         rk = {$urandom(), $urandom_range(0, 65535)};
         step(rk, ($urandom_range(0, 2) != 0));
      end
      step(48'hFFFFFFFFFFFF, 1'b1);

      // Asynchronous reset between edges while hf_vld is high
      #2;
      hf_in = 48'h000000000C00;
      reset = 1'b1;
      #1;
      chk("arst_out_q", {22'd0, hf_out_q}, 32'd0);
      chk("arst_vld", {31'd0, hf_vld}, 32'd0);
      chk("arst_comb", {22'd0, hf_out}, 32'h003);
      @(negedge clk);
      hf_en = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_q", {22'd0, hf_out_q}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      held  = 10'h0;
      exp_q.delete();
      step(48'h5555AAAA3C3C, 1'b0);
      step(48'h5555AAAA3C3C, 1'b1);
      step(48'h0, 1'b0);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
